// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline (master) and the hazard controller (slave):
// stage hazard inputs in, per-stage write enables, flushes and the stall counter out.
interface hazard_ctrl_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
);
   logic [ADDR_WIDTH-1:0] id_rs1_addr;
   logic [ADDR_WIDTH-1:0] id_rs2_addr;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic [ADDR_WIDTH-1:0] ex_rd_addr;
   logic                  ex_mem_r;
   logic                  ex_busy;
   logic                  ex_redirect;
   logic                  mem_req;
   logic                  dmem_ready;
   logic                  pc_we;
   logic                  if_id_we;
   logic                  id_ex_we;
   logic                  ex_mem_we;
   logic                  mem_wb_we;
   logic                  if_id_flush;
   logic                  id_ex_flush;
   logic                  ex_mem_flush;
   logic [CNT_WIDTH-1:0]  stall_cycles;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             ex_rd_addr, ex_mem_r, ex_busy, ex_redirect, mem_req, dmem_ready,
      input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
             if_id_flush, id_ex_flush, ex_mem_flush, stall_cycles
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             ex_rd_addr, ex_mem_r, ex_busy, ex_redirect, mem_req, dmem_ready,
      output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
             if_id_flush, id_ex_flush, ex_mem_flush, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, dmem wait freeze, EX busy stall and
// redirect flush, with a saturating count of cycles in which the PC was held.
//
// state (lu_cnt) | meaning
// 0              | no pending load-use bubbles; a new hazard may be accepted
// 1..6           | extra load-use bubbles still to insert
module hazard_ctrl_unit #(
   parameter int ADDR_WIDTH     = 5,
   parameter int LOAD_USE_STALL = 1,
   parameter int CNT_WIDTH      = 32
) (
   input  logic       clk,
   input  logic       rst,
   hazard_ctrl_if.slave hc
);
   localparam logic [ADDR_WIDTH-1:0] REG_X0    = '0;
   localparam logic [2:0]            LU_RELOAD = 3'(LOAD_USE_STALL - 1);

   logic [2:0]           lu_cnt;
   logic [CNT_WIDTH-1:0] stall_cnt;
   logic                 hazard_lu;
   logic                 mem_wait;

   assign hazard_lu = hc.ex_mem_r && (hc.ex_rd_addr != REG_X0) &&
                      ((hc.id_rs1_used && (hc.id_rs1_addr == hc.ex_rd_addr)) ||
                       (hc.id_rs2_used && (hc.id_rs2_addr == hc.ex_rd_addr)));
   assign mem_wait  = hc.mem_req && !hc.dmem_ready;

   always_comb begin
      hc.pc_we        = 1'b0;
      hc.if_id_we     = 1'b0;
      hc.id_ex_we     = 1'b0;
      hc.ex_mem_we    = 1'b0;
      hc.mem_wb_we    = 1'b0;
      hc.if_id_flush  = 1'b0;
      hc.id_ex_flush  = 1'b0;
      hc.ex_mem_flush = 1'b0;
      if (rst) begin
         hc.if_id_flush  = 1'b1;
         hc.id_ex_flush  = 1'b1;
         hc.ex_mem_flush = 1'b1;
      end else if (mem_wait) begin
         // whole pipe frozen, nothing to do
      end else if (hc.ex_redirect) begin
         hc.pc_we       = 1'b1;
         hc.if_id_we    = 1'b1;
         hc.id_ex_we    = 1'b1;
         hc.ex_mem_we   = 1'b1;
         hc.mem_wb_we   = 1'b1;
         hc.if_id_flush = 1'b1;
         hc.id_ex_flush = 1'b1;
      end else if (hc.ex_busy) begin
         hc.ex_mem_we    = 1'b1;
         hc.ex_mem_flush = 1'b1;
         hc.mem_wb_we    = 1'b1;
      end else if ((lu_cnt != 3'd0) || hazard_lu) begin
         hc.id_ex_we    = 1'b1;
         hc.ex_mem_we   = 1'b1;
         hc.mem_wb_we   = 1'b1;
         hc.id_ex_flush = 1'b1;
      end else begin
         hc.pc_we     = 1'b1;
         hc.if_id_we  = 1'b1;
         hc.id_ex_we  = 1'b1;
         hc.ex_mem_we = 1'b1;
         hc.mem_wb_we = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_cnt    <= 3'd0;
         stall_cnt <= '0;
      end else begin
         if (!mem_wait) begin
            if (hc.ex_redirect)
               lu_cnt <= 3'd0;
            else if (hc.ex_busy)
               lu_cnt <= lu_cnt;
            else if (lu_cnt != 3'd0)
               lu_cnt <= lu_cnt - 3'd1;
            else if (hazard_lu)
               lu_cnt <= LU_RELOAD;
         end
         if (!hc.pc_we && (stall_cnt != {CNT_WIDTH{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign hc.stall_cycles = stall_cnt;
endmodule
